// File: rtl/fifo_sync_param.sv
// rtl/fifo_sync_param.sv - single-clock first-word-fall-through FIFO with occupancy and threshold flags
// Optional synchronous flush port enabled by defining FIFO_SYNC_FLUSH_EN.
module fifo_sync_param #(
  parameter int DATA_W    = 42,
  parameter int DEPTH     = 4,
  parameter int AFULL_TH  = DEPTH - 1,
  parameter int AEMPTY_TH = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_W-1:0]          wdata,
  input  logic                       valid_i,
  output logic                       ready_o,
  output logic [DATA_W-1:0]          rdata,
  output logic                       valid_o,
  input  logic                       ready_i,
`ifdef FIFO_SYNC_FLUSH_EN
  input  logic                       flush_i,
`endif
  output logic [$clog2(DEPTH):0]     count,
  output logic                       almost_full,
  output logic                       almost_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C   = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic              flush;
  logic              push;
  logic              pop;

`ifdef FIFO_SYNC_FLUSH_EN
  assign flush = flush_i;
`else
  assign flush = 1'b0;
`endif

  // Flush gates both handshakes so nothing moves during the flush cycle.
  assign ready_o      = (count != FULL_C) && !flush;
  assign valid_o      = (count != '0) && !flush;
  assign rdata        = mem[rptr];
  assign almost_full  = (count >= AFULL_C);
  assign almost_empty = (count <= AEMPTY_C);

  assign push = valid_i && ready_o;
  assign pop  = valid_o && ready_i;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + AW'(1);
      end
      if (pop) begin
        rptr <= rptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_sync_param.sv
// tb/tb_fifo_sync_param.sv - directed self-checking bench for fifo_sync_param (DATA_W=42, DEPTH=4)
// Flush scenario is exercised only when FIFO_SYNC_FLUSH_EN is defined.
module tb_fifo_sync_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [41:0] wdata;
  logic        valid_i;
  logic        ready_o;
  logic [41:0] rdata;
  logic        valid_o;
  logic        ready_i;
  logic [2:0]  count;
  logic        almost_full;
  logic        almost_empty;
`ifdef FIFO_SYNC_FLUSH_EN
  logic        flush_i;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [41:0] q [$];

  always #5 clk = ~clk;

  fifo_sync_param #(.DATA_W(42), .DEPTH(4), .AFULL_TH(3), .AEMPTY_TH(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wdata        (wdata),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .rdata        (rdata),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
`ifdef FIFO_SYNC_FLUSH_EN
    .flush_i      (flush_i),
`endif
    .count        (count),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n   = 1'b0;
    wdata   = '0;
    valid_i = 1'b0;
    ready_i = 1'b0;
`ifdef FIFO_SYNC_FLUSH_EN
    flush_i = 1'b0;
`endif
    #3;
    check("rst_count", 64'(count), 0);
    check("rst_valid", 64'(valid_o), 0);
    check("rst_ready", 64'(ready_o), 1);
    check("rst_aempty", 64'(almost_empty), 1);
    check("rst_afull", 64'(almost_full), 0);
    step();
    rst_n = 1'b1;

    // Fill 1..4 with consumer stalled; thresholds checked along the way
    for (int i = 1; i <= 4; i++) begin
      valid_i = 1'b1;
      wdata   = 42'(i);
      step();
      check("fill_count", 64'(count), 64'(i));
      check("fill_afull", 64'(almost_full), (i >= 3) ? 64'd1 : 64'd0);
      check("fill_aempty", 64'(almost_empty), (i <= 1) ? 64'd1 : 64'd0);
      check("fill_head", 64'(rdata), 64'd1);
    end
    check("full_ready", 64'(ready_o), 0);
    wdata = 42'h5;
    step();
    check("ovf_count", 64'(count), 4);

    // Drain in order
    valid_i = 1'b0;
    ready_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("drain_valid", 64'(valid_o), 1);
      check("drain_data", 64'(rdata), 64'(i));
      step();
    end
    check("empty_valid", 64'(valid_o), 0);
    check("empty_aempty", 64'(almost_empty), 1);
    check("empty_count", 64'(count), 0);

    // Empty boundary: push and pop requested, only push lands
    valid_i = 1'b1;
    wdata   = 42'h10;
    step();
    check("eb_count", 64'(count), 1);
    check("eb_valid", 64'(valid_o), 1);
    check("eb_data", 64'(rdata), 64'h10);
    ready_i = 1'b0;
    wdata   = 42'h11;
    step();
    check("pre_stream_count", 64'(count), 2);
    q.push_back(42'h10);
    q.push_back(42'h11);

    // Streaming at count=2 across pointer wrap
    valid_i = 1'b1;
    ready_i = 1'b1;
    for (int k = 0; k < 12; k++) begin
      wdata = 42'h20 + 42'(k);
      check("stream_data", 64'(rdata), 64'(q[0]));
      void'(q.pop_front());
      q.push_back(wdata);
      step();
      check("stream_count", 64'(count), 2);
    end

    // Full boundary: fill, then push+pop at full -> only pop
    ready_i = 1'b0;
    wdata = 42'h40; q.push_back(wdata); step();
    wdata = 42'h41; q.push_back(wdata); step();
    check("fb_full", 64'(count), 4);
    ready_i = 1'b1;
    wdata   = 42'h50;
    void'(q.pop_front());
    step();
    check("fb_count", 64'(count), 3);
    check("fb_ready", 64'(ready_o), 1);
    valid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("fb_drain", 64'(rdata), 64'(q[0]));
      void'(q.pop_front());
      step();
    end
    check("fb_empty", 64'(valid_o), 0);

    // Mid-stream asynchronous reset at count=3
    ready_i = 1'b0;
    valid_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wdata = 42'h61 + 42'(k);
      step();
    end
    check("mr_pre", 64'(count), 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_count", 64'(count), 0);
    check("mr_valid", 64'(valid_o), 0);
    #1;
    wdata = 42'hA;
    rst_n = 1'b1;
    step();
    check("mr_push_count", 64'(count), 1);
    check("mr_push_data", 64'(rdata), 64'hA);

`ifdef FIFO_SYNC_FLUSH_EN
    wdata = 42'hB; step();
    wdata = 42'hC; step();
    check("fl_pre", 64'(count), 3);
    flush_i = 1'b1;
    #1;
    check("fl_gate_ready", 64'(ready_o), 0);
    check("fl_gate_valid", 64'(valid_o), 0);
    step();
    flush_i = 1'b0;
    valid_i = 1'b0;
    check("fl_count", 64'(count), 0);
    check("fl_valid", 64'(valid_o), 0);
    valid_i = 1'b1;
    wdata   = 42'hA;
    step();
    check("fl_push_data", 64'(rdata), 64'hA);
    check("fl_push_count", 64'(count), 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_sync_param.md
# fifo_sync_param

- Single-clock, parametrised FIFO; successor to the fixed 4-entry 42-bit channel buffer.
- Configurable data width and depth, occupancy count, programmable almost-full/almost-empty flags and an optional synchronous flush.
- Sits between a producer and a consumer in the same clock domain, using valid/ready handshakes on both sides.
- Read data is first-word-fall-through: the head entry is presented while `valid_o` is high.

## Interface

**Parameters**

- `DATA_W`, default 42: payload width in bits.
- `DEPTH`, default 4: number of entries. Must be a power of two, ≥2.
- `AFULL_TH`, default DEPTH-1: `almost_full` asserts when count ≥ AFULL_TH.
- `AEMPTY_TH`, default 1: `almost_empty` asserts when count ≤ AEMPTY_TH.

**Ports**

- `clk` in 1: the only clock. All state changes on its rising edge.
- `rst_n` in 1: asynchronous reset, active-low.
- `wdata` in DATA_W: write payload.
- `valid_i` in 1: producer has `wdata` valid.
- `ready_o` out 1: FIFO can accept a write.
- `rdata` out DATA_W: head-entry payload.
- `valid_o` out 1: `rdata` is valid.
- `ready_i` in 1: consumer accepts `rdata`.
- `count` out $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `almost_full` out 1: threshold flag.
- `almost_empty` out 1: threshold flag.
- `flush_i` in 1: synchronous flush. Present only with `FIFO_SYNC_FLUSH_EN`.

## Operation

- **Handshakes.** push = `valid_i` & `ready_o`; pop = `valid_o` & `ready_i`.
- **Storage.**
  - Array of DEPTH × DATA_W.
  - Write pointer and read pointer are each $clog2(DEPTH) bits and wrap modulo DEPTH naturally.
  - The array is not reset.
- **On push:** mem[wptr] ← `wdata`, then wptr+1.
- **On pop:** rptr+1.
- **Count update:** `count` ← `count` + push − pop.
  - Simultaneous push and pop leaves `count` unchanged; both pointers advance.
- **Output decode** (all combinational from registered state only):
  - `ready_o` = (`count` != DEPTH).
  - `valid_o` = (`count` != 0).
  - `rdata` = mem[rptr].
  - No input-to-output combinational path, except the flush gating described below.
- **Full boundary.** When `count` = DEPTH, `ready_o` = 0 even if a pop occurs in the same cycle. There is no write-through on full.
- **Empty boundary.** When `count` = 0, `valid_o` = 0 even if a push occurs in the same cycle. There is no bypass; `rdata` is don't-care.
- **Ignored requests.** A `valid_i` while `ready_o` = 0, or a `ready_i` while `valid_o` = 0, has no effect. Overflow and underflow are impossible by construction.
- **Flags.** `almost_full` = (`count` ≥ AFULL_TH); `almost_empty` = (`count` ≤ AEMPTY_TH).
- **Reset values (async, while `rst_n` = 0):**
  - Pointers = 0 and `count` = 0.
  - Therefore `valid_o` = 0, `ready_o` = 1, `almost_empty` = 1, and `almost_full` = (AFULL_TH = 0).
  - `rdata` is don't-care.
- **Reset mid-operation.** Contents are discarded immediately on `rst_n` fall, regardless of any handshake in flight.
- **Reset release.** The first push is accepted on the first rising edge after `rst_n` deasserts.

## Timing

- Write-to-read latency is 1 cycle: a push at edge N gives `valid_o` = 1 and `rdata` = that word in cycle N+1.
- Pop-to-ready recovery from full is 1 cycle: a pop at edge N gives `ready_o` = 1 in cycle N+1.
- `count` and both flags reflect the update made at edge N during cycle N+1.
- Sustained throughput is 1 push and 1 pop per cycle when 0 < `count` < DEPTH.

## Configuration

- **Macro:** `FIFO_SYNC_FLUSH_EN`.
- **Defined:**
  - Adds the `flush_i` port.
  - While `flush_i` = 1, `ready_o` and `valid_o` are forced to 0, so no push or pop occurs.
  - At the rising edge with `flush_i` = 1: pointers ← 0 and `count` ← 0.
  - The cycle after flush matches the post-reset state.
  - Flush takes priority over any handshake.
- **Undefined:** no `flush_i` port and no gating. Behaviour is exactly as described above.

## Test plan

All scenarios use DATA_W=42 and DEPTH=4.

1. **Reset, then fill:** assert reset, then push 0x1, 0x2, 0x3, 0x4 on consecutive cycles with `ready_i` = 0 → `count` 1,2,3,4; `ready_o` = 0 after the 4th push; a 5th `valid_i` with 0x5 is ignored and `count` stays 4.
2. **Drain in order:** from full, `ready_i` = 1 for 4 cycles → `rdata` 0x1, 0x2, 0x3, 0x4 in order; `valid_o` = 0 and `almost_empty` = 1 afterwards.
3. **Simultaneous push/pop at count=2 with pointer wrap:** run 12 cycles with `valid_i` = `ready_i` = 1 → `count` stays 2 and output order equals input order across the wrap.
4. **Full and empty boundaries:** at full with `ready_i` = 1 and `valid_i` = 1 → only the pop happens; `count` = 3 next cycle. At empty with both high → only the push happens; `count` = 1 and `valid_o` = 1 next cycle.
5. **Thresholds:** with AFULL_TH=3 and AEMPTY_TH=1 → `almost_full` rises when `count` goes 2→3; `almost_empty` falls when `count` goes 1→2.
6. **Mid-stream reset and flush:** with `count` = 3, pulse `rst_n` low asynchronously (and, with `FIFO_SYNC_FLUSH_EN`, separately assert `flush_i` 1 cycle) → `count` = 0 and `valid_o` = 0 next cycle; the next push 0xA is read back first.
